// File: rtl/parallel_hps_send_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parallel_hps_send_pkg                                                      |
// | Shared widths and FSM state type for the HPS parallel word sender.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package parallel_hps_send_pkg;

    localparam int PAYLOAD_W = 31;
    localparam int SEQ_BIT   = 31;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        ALIGN    = 2'd0,
        IDLE     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/parallel_hps_send_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parallel_hps_send_fifo                                                     |
// | Synchronous FIFO with a registered read port that always holds the head.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module parallel_hps_send_fifo #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = parallel_hps_send_pkg::PAYLOAD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [PAYLOAD_W-1:0]       i_wr_data,
    input  logic                       i_rd_en,
    output logic [PAYLOAD_W-1:0]       o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("DEPTH must be a power of two and at least 2");
    end

    logic [PAYLOAD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LVL_W-1:0]     r_count;
    logic [PAYLOAD_W-1:0] r_rd_data;
    logic                 w_push;
    logic                 w_pop;
    logic [AW-1:0]        w_rd_ptr_nxt;

    assign o_full       = (r_count == LVL_W'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_level      = r_count;
    assign o_rd_data    = r_rd_data;
    assign w_push       = i_wr_en & ~o_full;
    assign w_pop        = i_rd_en & ~o_empty;
    assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // The read register tracks the slot the head will occupy after this edge,
    // bypassing the write data when that slot is being written right now.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
                r_rd_data <= i_wr_data;
            end else begin
                r_rd_data <= r_mem[w_rd_ptr_nxt];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/parallel_hps_word_sender.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parallel_hps_word_sender                                                   |
// | Presents queued 31-bit words to the HPS PIO with a toggle-bit handshake.   |
// | Optional ack timeout flag: define PHS_SEND_TIMEOUT_EN.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module parallel_hps_word_sender
    import parallel_hps_send_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SEQ_BIT:0]     parallel_input_export,
    input  logic                 hps_valid_export,
    output logic                 busy,
    output logic [CNT_W-1:0]     words_sent,
    output logic                 timeout_err
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_pop;
    logic                 w_ack_done;
    logic                 w_full;
    logic                 w_empty;
    logic [LVL_W-1:0]     w_level;
    logic [PAYLOAD_W-1:0] w_head;
    logic                 r_ack_q;
    logic                 r_ack_primed;
    logic [SEQ_BIT:0]     r_out;
    logic [CNT_W-1:0]     r_words_sent;
    logic                 w_seq;
    logic                 w_ack_match;
    logic                 w_unused_level;

    parallel_hps_send_fifo #(
        .DEPTH     (DEPTH),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_fifo (
        .clk       (clk_clk),
        .rst       (reset_reset),
        .i_wr_en   (in_valid),
        .i_wr_data (in_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    assign w_unused_level        = ^w_level;
    assign w_seq                 = r_out[SEQ_BIT];
    assign w_ack_match           = (r_ack_q == w_seq);
    assign in_ready              = ~w_full;
    assign parallel_input_export = r_out;
    assign busy                  = (r_state != IDLE);
    assign words_sent            = r_words_sent;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= ALIGN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ALIGN waits one cycle for ack_q to hold a real sample of the HPS PIO,
    // so a valid bit left high by a previous run is not mistaken for a match.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_ack_done  = 1'b0;
        case (r_state)
            ALIGN: begin
                if (r_ack_primed && w_ack_match) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (w_ack_match) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = ALIGN;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_ack_q      <= 1'b0;
            r_ack_primed <= 1'b0;
            r_out        <= '0;
            r_words_sent <= '0;
        end else begin
            r_ack_q      <= hps_valid_export;
            r_ack_primed <= 1'b1;
            if (w_pop) begin
                r_out <= {~w_seq, w_head};
            end
            if (w_ack_done) begin
                r_words_sent <= r_words_sent + CNT_W'(1);
            end
        end
    end

`ifdef PHS_SEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;

    // The counter saturates at the threshold; the word stays presented.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else if (w_pop) begin
            r_to_cnt <= '0;
        end else if (r_state == WAIT_ACK) begin
            if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                r_timeout_err <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parallel_hps_word_sender.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_parallel_hps_word_sender                                                |
// | Self-checking bench with an HPS emulator and a queue reference model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_parallel_hps_word_sender;

    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [30:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] pout;
    logic        hps = 1'b0;
    logic        busy;
    logic [15:0] words_sent;
    logic        timeout_err;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [30:0] model_q[$];
    logic        model_seq;
    int          model_sent;
    logic [31:0] last_out;

    always #5 clk = ~clk;

    parallel_hps_word_sender #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_clk               (clk),
        .reset_reset           (rst),
        .in_data               (in_data),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .parallel_input_export (pout),
        .hps_valid_export      (hps),
        .busy                  (busy),
        .words_sent            (words_sent),
        .timeout_err           (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_q.delete();
        model_seq  = 1'b0;
        model_sent = 0;
        last_out   = '0;
    endtask

    task automatic push(input logic [30:0] w);
        in_data  = w;
        in_valid = 1'b1;
        model_q.push_back(w);
        tick();
        in_valid = 1'b0;
    endtask

    // HPS view of a new word: the toggle bit differs from its own last ack.
    task automatic wait_new_word(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (pout[31] != hps) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (!busy) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Expected next presented word from the model; advances the model seq.
    function automatic logic [31:0] model_next();
        logic [30:0] w;
        w = (model_q.size() > 0) ? model_q.pop_front() : 31'h0;
        model_seq = ~model_seq;
        last_out  = {model_seq, w};
        return last_out;
    endfunction

    task automatic test_reset();
        bit          f;
        logic [31:0] e;
        hps = 1'b1;
        do_reset();
        n_checks++; if (pout !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h want %h", pout, 32'h0); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
        n_checks++; if (words_sent !== 16'h0) begin n_fail++; $display("FAIL reset_words_sent: got %h want 0", words_sent); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
        push(31'h0000_0001);
        repeat (5) tick();
        n_checks++; if (busy !== 1'b1 || pout !== 32'h0) begin n_fail++; $display("FAIL align_hold: busy %b out %h want busy 1 out 0", busy, pout); end
        hps = 1'b0;
        wait_new_word(10, f);
        e = model_next();
        n_checks++; if (!f || pout !== e || e !== 32'h8000_0001) begin n_fail++; $display("FAIL align_release: got %h want %h", pout, 32'h8000_0001); end
        hps = model_seq;
        model_sent++;
        wait_idle(10, f);
        n_checks++; if (!f || words_sent !== 16'(model_sent)) begin n_fail++; $display("FAIL align_ack: got %0d want %0d", words_sent, model_sent); end
    endtask

    task automatic test_directed();
        bit          f;
        logic [31:0] e;
        hps = 1'b0;
        do_reset();
        repeat (3) tick();
        push(31'h1234_5678);
        n_checks++; if (pout !== 32'h0) begin n_fail++; $display("FAIL dir_early: got %h want 0", pout); end
        tick();
        e = model_next();
        n_checks++; if (pout !== 32'h9234_5678 || e !== 32'h9234_5678) begin n_fail++; $display("FAIL dir_first: got %h want %h", pout, 32'h9234_5678); end
        hps = 1'b1;
        model_sent++;
        wait_idle(10, f);
        n_checks++; if (!f || words_sent !== 16'd1) begin n_fail++; $display("FAIL dir_ack: got %0d want 1", words_sent); end
        push(31'h0000_00AB);
        tick();
        e = model_next();
        n_checks++; if (pout !== 32'h0000_00AB || e !== 32'h0000_00AB) begin n_fail++; $display("FAIL dir_second: got %h want %h", pout, 32'h0000_00AB); end
        hps = model_seq;
        model_sent++;
        wait_idle(10, f);
    endtask

    task automatic test_capacity();
        bit          f;
        int          accepted;
        logic [31:0] e;
        accepted = 0;
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            in_data = 31'($urandom);
            if (in_ready) begin
                model_q.push_back(in_data);
                accepted++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (accepted != DEPTH + 1) begin n_fail++; $display("FAIL cap_accepted: got %0d want %0d", accepted, DEPTH + 1); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL cap_full: got %b want 0", in_ready); end
        for (int i = 0; i < DEPTH + 1; i++) begin
            wait_new_word(20, f);
            e = model_next();
            n_checks++; if (!f || pout !== e) begin n_fail++; $display("FAIL cap_order[%0d]: got %h want %h", i, pout, e); end
            hps = model_seq;
            model_sent++;
        end
        wait_idle(10, f);
        n_checks++; if (!f || words_sent !== 16'(model_sent) || in_ready !== 1'b1) begin n_fail++; $display("FAIL cap_drain: sent %0d want %0d ready %b", words_sent, model_sent, in_ready); end
    endtask

    task automatic test_idle_toggle();
        hps = ~hps;
        tick();
        hps = ~hps;
        tick();
        repeat (6) tick();
        n_checks++; if (busy !== 1'b0 || words_sent !== 16'(model_sent) || pout !== last_out) begin n_fail++; $display("FAIL idle_toggle: busy %b sent %0d out %h want 0 %0d %h", busy, words_sent, pout, model_sent, last_out); end
    endtask

    task automatic test_timeout();
        bit          f;
        logic [31:0] e;
        push(31'($urandom));
        wait_new_word(10, f);
        e = model_next();
        n_checks++; if (!f || pout !== e) begin n_fail++; $display("FAIL to_word: got %h want %h", pout, e); end
`ifdef PHS_SEND_TIMEOUT_EN
        repeat (TO + 2) tick();
        n_checks++; if (timeout_err !== 1'b1 || pout !== e) begin n_fail++; $display("FAIL to_flag: got %b out %h want 1 %h", timeout_err, pout, e); end
`else
        repeat (3 * TO) tick();
        n_checks++; if (timeout_err !== 1'b0 || pout !== e) begin n_fail++; $display("FAIL to_flag_off: got %b out %h want 0 %h", timeout_err, pout, e); end
`endif
        hps = model_seq;
        model_sent++;
        wait_idle(10, f);
        n_checks++; if (!f || words_sent !== 16'(model_sent)) begin n_fail++; $display("FAIL to_ack: got %0d want %0d", words_sent, model_sent); end
`ifdef PHS_SEND_TIMEOUT_EN
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
`else
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_sticky_off: got %b want 0", timeout_err); end
`endif
    endtask

    task automatic test_reset_midwait();
        bit          f;
        logic [31:0] e;
        logic [30:0] w;
        for (int i = 0; i < 5; i++) push(31'($urandom));
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy); end
        hps = 1'b0;
        do_reset();
        n_checks++; if (pout !== 32'h0 || in_ready !== 1'b1 || words_sent !== 16'h0) begin n_fail++; $display("FAIL mid_reset: out %h ready %b sent %0d want 0 1 0", pout, in_ready, words_sent); end
        repeat (10) tick();
        n_checks++; if (pout !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_empty: out %h busy %b want 0 0", pout, busy); end
        w = 31'($urandom);
        push(w);
        wait_new_word(10, f);
        e = model_next();
        n_checks++; if (!f || pout !== e || e !== {1'b1, w}) begin n_fail++; $display("FAIL mid_fresh: got %h want %h", pout, {1'b1, w}); end
        hps = model_seq;
        model_sent++;
        wait_idle(10, f);
    endtask

    task automatic test_random();
        bit          pending;
        int          delay;
        bit          done;
        logic [31:0] e;
        pending = 1'b0;
        delay   = 0;
        done    = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!pending && (pout[31] != hps)) begin
                n_checks++; if (model_q.size() == 0) begin n_fail++; $display("FAIL rnd_spurious: out %h with empty model", pout); end
                e = model_next();
                n_checks++; if (pout !== e) begin n_fail++; $display("FAIL rnd_word: got %h want %h", pout, e); end
                pending = 1'b1;
                delay   = $urandom_range(0, 4);
            end else if (pending) begin
                if (delay == 0) begin
                    hps = model_seq;
                    model_sent++;
                    pending = 1'b0;
                end else begin
                    delay--;
                end
            end
            n_checks++; if (in_ready !== (model_q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready: got %b want %b", in_ready, model_q.size() < DEPTH); end
            if (c < 400) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 31'($urandom);
                if (in_valid && in_ready) model_q.push_back(in_data);
            end else begin
                in_valid = 1'b0;
                if (!pending && model_q.size() == 0 && !busy) begin
                    done = 1'b1;
                    break;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (!done || words_sent !== 16'(model_sent)) begin n_fail++; $display("FAIL rnd_drain: done %b sent %0d want %0d", done, words_sent, model_sent); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_capacity();
        test_idle_toggle();
        test_timeout();
        test_reset_midwait();
        test_random();
        test_idle_toggle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
